// File: rtl/rx_frame_sync_ctrl.sv
// rx_frame_sync_ctrl
// Acquisition/tracking sequencer for the QPSK receiver. Restarts the receiver,
// searches for SOF, tracks SOF periodicity (lock/miss) and packs each frame's
// 2-bit symbols into bytes on an AXI-Stream-style master with tlast.
// Optional build macro: RX_FRAME_SYNC_STATS_EN adds frame_cnt / miss_total.
module rx_frame_sync_ctrl #(
   parameter int FRAME_SYMS     = 63,
   parameter int SOF_PERIOD     = 704,
   parameter int SOF_TOL        = 16,
   parameter int SEARCH_TIMEOUT = 4096,
   parameter int MAX_MISS       = 3,
   parameter int RESTART_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       sof_pulse,
   input  logic       sym_valid,
   input  logic [1:0] sym_data,
   output logic       rx_rst,
   output logic       locked,
   output logic [7:0] m_tdata,
   output logic       m_tvalid,
   output logic       m_tlast,
   input  logic       m_tready,
   output logic       overflow
`ifdef RX_FRAME_SYNC_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] miss_total
`endif
);

   localparam int SC_W  = $clog2(SOF_PERIOD + SOF_TOL + 2);
   localparam int TMO_W = $clog2(SEARCH_TIMEOUT + 1);
   localparam int RC_W  = $clog2(RESTART_CYCLES + 1);
   localparam int SYM_W = $clog2(FRAME_SYMS + 1);
   localparam int MC_W  = $clog2(MAX_MISS + 1);

   // sof_cnt_q is cleared on the SOF edge itself, so it holds (cycles since SOF - 1).
   // The bounds below are shifted by one so that the window is on true SOF spacing.
   localparam logic [SC_W-1:0]  WIN_LO   = SC_W'(SOF_PERIOD - SOF_TOL - 1);
   localparam logic [SC_W-1:0]  WIN_HI   = SC_W'(SOF_PERIOD + SOF_TOL - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEARCH_TIMEOUT - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESTART_CYCLES - 1);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(FRAME_SYMS - 1);
   localparam logic [MC_W-1:0]  MISS_MAX = MC_W'(MAX_MISS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESTART,
      ST_SEARCH,
      ST_FRAME,
      ST_GAP
   } state_t;

   state_t             state_q,   state_d;
   logic [RC_W-1:0]    rc_q,      rc_d;
   logic [TMO_W-1:0]   tmo_q,     tmo_d;
   logic [SC_W-1:0]    sof_cnt_q, sof_cnt_d;
   logic [SYM_W-1:0]   sym_cnt_q, sym_cnt_d;
   logic [MC_W-1:0]    miss_q,    miss_d;
   logic [7:0]         acc_q,     acc_d;
   logic               rx_rst_q,  rx_rst_d;
   logic               locked_q,  locked_d;
   logic               tvalid_q,  tvalid_d;
   logic [7:0]         tdata_q,   tdata_d;
   logic               tlast_q,   tlast_d;
   logic               ovf_q,     ovf_d;
`ifdef RX_FRAME_SYNC_STATS_EN
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic [15:0]        miss_tot_q,  miss_tot_d;
`endif

   logic               miss;
   logic               frame_done;
   logic               byte_emit;
   logic               byte_last;
   logic               byte_landed;
   logic [7:0]         byte_val;
   logic [7:0]         nxt_acc;

   // Next-state logic: sequencer, SOF tracking, symbol packing and output holding register
   always_comb begin
      state_d     = state_q;
      rc_d        = rc_q;
      tmo_d       = tmo_q;
      sym_cnt_d   = sym_cnt_q;
      miss_d      = miss_q;
      acc_d       = acc_q;
      rx_rst_d    = rx_rst_q;
      locked_d    = locked_q;
      tvalid_d    = tvalid_q;
      tdata_d     = tdata_q;
      tlast_d     = tlast_q;
      ovf_d       = ovf_q;
      miss        = 1'b0;
      frame_done  = 1'b0;
      byte_emit   = 1'b0;
      byte_last   = 1'b0;
      byte_landed = 1'b0;
      byte_val    = 8'h00;
      nxt_acc     = acc_q;
`ifdef RX_FRAME_SYNC_STATS_EN
      frame_cnt_d = frame_cnt_q;
      miss_tot_d  = miss_tot_q;
`endif

      sof_cnt_d = (sof_cnt_q == '1) ? sof_cnt_q : sof_cnt_q + SC_W'(1);

      if (tvalid_q && m_tready) begin
         tvalid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            rx_rst_d = 1'b1;
            if (enable) begin
               state_d = ST_RESTART;
               rc_d    = '0;
            end
         end

         ST_RESTART: begin
            rx_rst_d = 1'b1;
            if (rc_q == RC_LAST) begin
               state_d  = ST_SEARCH;
               rx_rst_d = 1'b0;
               tmo_d    = '0;
            end else begin
               rc_d = rc_q + RC_W'(1);
            end
         end

         ST_SEARCH: begin
            if (sof_pulse) begin
               state_d   = ST_FRAME;
               sof_cnt_d = '0;
               sym_cnt_d = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d  = ST_RESTART;
               rc_d     = '0;
               rx_rst_d = 1'b1;
               locked_d = 1'b0;
               miss_d   = '0;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_FRAME: begin
            frame_done = sym_valid && (sym_cnt_q == SYM_LAST);
            // A symbol that completes the frame beats the SOF-window timeout
            if (!frame_done && (sof_cnt_q >= WIN_HI)) begin
               miss = 1'b1;
            end else if (sym_valid) begin
               nxt_acc = (sym_cnt_q[1:0] == 2'd0) ? 8'h00 : acc_q;
               case (sym_cnt_q[1:0])
                  2'd0:    nxt_acc[7:6] = sym_data;
                  2'd1:    nxt_acc[5:4] = sym_data;
                  2'd2:    nxt_acc[3:2] = sym_data;
                  default: nxt_acc[1:0] = sym_data;
               endcase
               acc_d     = nxt_acc;
               sym_cnt_d = sym_cnt_q + SYM_W'(1);
               if (frame_done || (sym_cnt_q[1:0] == 2'd3)) begin
                  byte_emit = 1'b1;
                  byte_val  = nxt_acc;
                  byte_last = frame_done;
               end
               if (frame_done) begin
                  state_d = ST_GAP;
               end
            end
         end

         ST_GAP: begin
            if (sof_pulse && (sof_cnt_q >= WIN_LO) && (sof_cnt_q <= WIN_HI)) begin
               state_d   = ST_FRAME;
               locked_d  = 1'b1;
               miss_d    = '0;
               sof_cnt_d = '0;
               sym_cnt_d = '0;
            end else if (sof_cnt_q > WIN_HI) begin
               miss = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (miss) begin
         if ((miss_q + MC_W'(1)) == MISS_MAX) begin
            state_d  = ST_RESTART;
            rc_d     = '0;
            rx_rst_d = 1'b1;
            locked_d = 1'b0;
            miss_d   = '0;
         end else begin
            state_d = ST_SEARCH;
            tmo_d   = '0;
            miss_d  = miss_q + MC_W'(1);
         end
      end

      // Single holding register: a new byte only lands if the slot is free this cycle
      if (byte_emit) begin
         if (!tvalid_q || m_tready) begin
            tvalid_d    = 1'b1;
            tdata_d     = byte_val;
            tlast_d     = byte_last;
            byte_landed = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

`ifdef RX_FRAME_SYNC_STATS_EN
      if (enable && byte_landed && byte_last) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (enable && miss && (miss_tot_q != 16'hFFFF)) begin
         miss_tot_d = miss_tot_q + 16'd1;
      end
`endif

      if (!enable) begin
         state_d   = ST_IDLE;
         rx_rst_d  = 1'b1;
         acc_d     = 8'h00;
         sym_cnt_d = '0;
         tvalid_d  = 1'b0;
         tdata_d   = 8'h00;
         tlast_d   = 1'b0;
         locked_d  = 1'b0;
         miss_d    = '0;
         ovf_d     = 1'b0;
      end
   end

   // State and output registers; async reset puts the receiver into restart
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rc_q        <= '0;
         tmo_q       <= '0;
         sof_cnt_q   <= '0;
         sym_cnt_q   <= '0;
         miss_q      <= '0;
         acc_q       <= 8'h00;
         rx_rst_q    <= 1'b1;
         locked_q    <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= 8'h00;
         tlast_q     <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef RX_FRAME_SYNC_STATS_EN
         frame_cnt_q <= 16'h0000;
         miss_tot_q  <= 16'h0000;
`endif
      end else begin
         state_q     <= state_d;
         rc_q        <= rc_d;
         tmo_q       <= tmo_d;
         sof_cnt_q   <= sof_cnt_d;
         sym_cnt_q   <= sym_cnt_d;
         miss_q      <= miss_d;
         acc_q       <= acc_d;
         rx_rst_q    <= rx_rst_d;
         locked_q    <= locked_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
         ovf_q       <= ovf_d;
`ifdef RX_FRAME_SYNC_STATS_EN
         frame_cnt_q <= frame_cnt_d;
         miss_tot_q  <= miss_tot_d;
`endif
      end
   end

   assign rx_rst   = rx_rst_q;
   assign locked   = locked_q;
   assign m_tdata  = tdata_q;
   assign m_tvalid = tvalid_q;
   assign m_tlast  = tlast_q;
   assign overflow = ovf_q;
`ifdef RX_FRAME_SYNC_STATS_EN
   assign frame_cnt  = frame_cnt_q;
   assign miss_total = miss_tot_q;
`endif

endmodule

// File: tb/tb_rx_frame_sync_ctrl.sv
// Testbench for rx_frame_sync_ctrl: table-driven frame packing, lock/miss and
// timeout sequences, backpressure/async reset corner cases, and randomized
// frames checked against a transaction-level byte model.
module tb_rx_frame_sync_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       sof_pulse;
   logic       sym_valid;
   logic [1:0] sym_data;
   logic       rx_rst;
   logic       locked;
   logic [7:0] m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready;
   logic       overflow;
`ifdef RX_FRAME_SYNC_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] miss_total;
`endif

   int n_chk = 0;
   int n_err = 0;

   rx_frame_sync_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .sof_pulse (sof_pulse),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .rx_rst    (rx_rst),
      .locked    (locked),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .overflow  (overflow)
`ifdef RX_FRAME_SYNC_STATS_EN
      ,
      .frame_cnt (frame_cnt),
      .miss_total(miss_total)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] sym;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_last;
   } vec_t;

   vec_t tbl [63];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Counts consecutive rx_rst-high samples; 'start' covers a high already observed
   task automatic count_rst_high(input int start, output int len);
      len = start;
      for (int i = 0; i < 50; i++) begin
         step();
         if (rx_rst) len++;
         else break;
      end
   endtask

   // 63 symbols 0,1,2,3,... back to back
   task automatic feed_frame(output int n_bytes, output int n_last);
      n_bytes = 0;
      n_last  = 0;
      for (int k = 0; k < 63; k++) begin
         sym_valid = 1'b1;
         sym_data  = 2'(k % 4);
         step();
         if (m_tvalid) n_bytes++;
         if (m_tvalid && m_tlast) n_last++;
      end
      sym_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, nb, nl, e;
      // reference-model state for randomized frames
      bit        hv, hl, ovf_m, in_frame;
      bit [7:0]  hd, acc, bval;
      int        cnt, drain;
      bit        done, blast, tr, sv;
      bit [1:0]  sd;

      // expected packing for symbols 0,1,2,3 repeating: bytes 00_01_10_11,
      // last byte has three symbols then zero padding
      for (int k = 0; k < 63; k++) begin
         tbl[k].sym       = 2'(k % 4);
         tbl[k].exp_valid = (k % 4 == 3) || (k == 62);
         tbl[k].exp_data  = (k == 62) ? 8'h18 : 8'h1B;
         tbl[k].exp_last  = (k == 62);
      end

      rst_n = 1'b1; enable = 1'b0; sof_pulse = 1'b0; sym_valid = 1'b0;
      sym_data = 2'b00; m_tready = 1'b1;
      #2 rst_n = 1'b0;
      idle(2);
      chk("rst_rx_rst",   rx_rst,   1);
      chk("rst_locked",   locked,   0);
      chk("rst_tvalid",   m_tvalid, 0);
      chk("rst_tdata",    m_tdata,  0);
      chk("rst_tlast",    m_tlast,  0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      idle(2);
      chk("idle_rx_rst", rx_rst, 1);

      // ---- restart length and basic frame packing ----
      enable = 1'b1;
      count_rst_high(0, len);
      chk("restart_len_enable", len, 8);
      sof_pulse = 1'b1; sym_valid = 1'b1; sym_data = 2'b11;
      step();
      sof_pulse = 1'b0;
      chk("sof_cycle_no_byte", m_tvalid, 0);
      chk("first_sof_not_locked", locked, 0);
      for (int k = 0; k < 63; k++) begin
         sym_valid = 1'b1;
         sym_data  = tbl[k].sym;
         step();
         chk($sformatf("tbl_valid_%0d", k), m_tvalid, tbl[k].exp_valid);
         if (tbl[k].exp_valid) begin
            chk($sformatf("tbl_data_%0d", k), m_tdata, tbl[k].exp_data);
            chk($sformatf("tbl_last_%0d", k), m_tlast, tbl[k].exp_last);
         end
      end
      sym_valid = 1'b0;

      // ---- lock on periodic SOF, then three misses ----
      idle(640);
      sof_pulse = 1'b1; step(); sof_pulse = 1'b0;  // 704 cycles after previous SOF
      chk("lock_on_2nd_sof", locked, 1);
      feed_frame(nb, nl);
      chk("frame_a_bytes", nb, 16);
      chk("frame_a_tlast", nl, 1);
      idle(657);
      sof_pulse = 1'b1; step(); sof_pulse = 1'b0;  // 721 cycles: outside window
      chk("miss1_locked", locked, 1);
      chk("miss1_no_restart", rx_rst, 0);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         sym_valid = 1'b1; sym_data = 2'(i);
         step();
         if (m_tvalid) nb++;
      end
      sym_valid = 1'b0;
      chk("search_ignores_syms", nb, 0);

      sof_pulse = 1'b1; step(); sof_pulse = 1'b0;
      feed_frame(nb, nl);
      chk("frame_b_bytes", nb, 16);
      idle(657);
      step();  // 721st cycle after SOF: second miss
      chk("miss2_locked", locked, 1);
      chk("miss2_no_restart", rx_rst, 0);
`ifdef RX_FRAME_SYNC_STATS_EN
      chk("stats_frame_cnt", frame_cnt, 3);
      chk("stats_miss_total", miss_total, 2);
`endif
      idle(9);
      chk("miss2_still_no_restart", rx_rst, 0);

      sof_pulse = 1'b1; step(); sof_pulse = 1'b0;
      feed_frame(nb, nl);
      e = 63;
      for (int i = 0; i < 800; i++) begin
         step();
         e++;
         if (rx_rst) break;
      end
      chk("miss3_restart_cycle", e, 721);
      chk("miss3_unlocked", locked, 0);
      count_rst_high(1, len);
      chk("miss3_restart_len", len, 8);

      // ---- search timeout ----
      e = 0;
      for (int i = 0; i < 5000; i++) begin
         step();
         e++;
         if (rx_rst) break;
      end
      chk("search_timeout_cycles", e, 4096);
      count_rst_high(1, len);
      chk("timeout_restart_len", len, 8);

      // ---- full backpressure ----
      m_tready = 1'b0;
      sof_pulse = 1'b1; step(); sof_pulse = 1'b0;
      feed_frame(nb, nl);
      chk("bp_tvalid", m_tvalid, 1);
      chk("bp_tdata",  m_tdata,  8'h1B);
      chk("bp_tlast",  m_tlast,  0);
      chk("bp_overflow", overflow, 1);
      idle(3);
      chk("bp_tdata_stable", m_tdata, 8'h1B);
      chk("bp_overflow_sticky", overflow, 1);

      // ---- async reset mid-frame with a byte held ----
      #3 rst_n = 1'b0;
      #1;
      chk("areset_tvalid",   m_tvalid, 0);
      chk("areset_rx_rst",   rx_rst,   1);
      chk("areset_locked",   locked,   0);
      chk("areset_overflow", overflow, 0);
`ifdef RX_FRAME_SYNC_STATS_EN
      chk("areset_frame_cnt", frame_cnt, 0);
`endif
      step();
      rst_n = 1'b1;
      enable = 1'b0;
      step();

      // ---- randomized frames against byte model ----
      for (int f = 0; f < 4; f++) begin
         enable = 1'b0; m_tready = 1'b1;
         step();
         chk("rnd_en_low_tvalid", m_tvalid, 0);
         chk("rnd_en_low_overflow", overflow, 0);
         enable = 1'b1;
         count_rst_high(0, len);
         chk("rnd_restart_len", len, 8);
         hv = 0; hl = 0; hd = 8'h00; ovf_m = 0; acc = 8'h00; cnt = 0; in_frame = 1;
         tr = 1'($urandom);
         sof_pulse = 1'b1; sym_valid = 1'b1; sym_data = 2'($urandom); m_tready = tr;
         if (hv && tr) hv = 0;
         step();
         sof_pulse = 1'b0;
         chk("rnd_sof_tvalid", m_tvalid, hv);
         drain = 0;
         for (int c = 0; c < 300 && drain < 8; c++) begin
            sv = ($urandom % 4) != 0;
            sd = 2'($urandom);
            tr = 1'($urandom);
            sym_valid = sv; sym_data = sd; m_tready = tr;
            done = 0; blast = 0; bval = 8'h00;
            if (in_frame && sv) begin
               acc = acc | (8'(sd) << (6 - 2 * (cnt % 4)));
               cnt++;
               if ((cnt % 4 == 0) || (cnt == 63)) begin
                  bval = acc; blast = (cnt == 63); acc = 8'h00; done = 1;
                  if (blast) in_frame = 0;
               end
            end
            if (done) begin
               if (!hv || tr) begin hv = 1; hd = bval; hl = blast; end
               else ovf_m = 1;
            end else if (hv && tr) begin
               hv = 0;
            end
            if (!in_frame) drain++;
            step();
            chk("rnd_tvalid", m_tvalid, hv);
            if (hv) begin
               chk("rnd_tdata", m_tdata, hd);
               chk("rnd_tlast", m_tlast, hl);
            end
            chk("rnd_overflow", overflow, ovf_m);
         end
         chk("rnd_frame_complete", in_frame, 0);
         sym_valid = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
